ram_march_bist: RTL and testbench



---
 rtl/ram_bist_pkg.sv | 61 ++++++
 rtl/bist_addr_counter.sv | 41 ++++
 rtl/ram_march_bist.sv | 164 ++++++++++++++++
 tb/tb_ram_march_bist.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- RAM BIST: FSM states, element numbering and
// the per-element operation table (direction, read/write backgrounds, op mix).
package ram_bist_pkg;

  typedef enum logic [3:0] {
    IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE
  } state_e;

  localparam logic [2:0] ELEM_M0   = 3'd0;
  localparam logic [2:0] ELEM_M1   = 3'd1;
  localparam logic [2:0] ELEM_M2   = 3'd2;
  localparam logic [2:0] ELEM_M3   = 3'd3;
  localparam logic [2:0] ELEM_M4   = 3'd4;
  localparam logic [2:0] ELEM_M5   = 3'd5;
  localparam logic [2:0] ELEM_NONE = 3'd6;

  typedef struct packed {
    logic up;      // 1: address 0 -> mem_size-1
    logic has_rd;
    logic rd_bg;   // expected read background bit
    logic has_wr;
    logic wr_bg;   // write background bit
  } elem_cfg_t;

  // Entries 6 and 7 describe "no march element": no ops at all.
  localparam elem_cfg_t ELEM_TBL [0:7] = '{
    '{up: 1'b1, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b0},
    '{up: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
    '{up: 1'b1, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
    '{up: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
    '{up: 1'b0, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
    '{up: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0},
    '{up: 1'b1, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0},
    '{up: 1'b1, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0}
  };

  function automatic logic [2:0] elem_num(input state_e s);
    case (s)
      M0:      return ELEM_M0;
      M1:      return ELEM_M1;
      M2:      return ELEM_M2;
      M3:      return ELEM_M3;
      M4:      return ELEM_M4;
      M5:      return ELEM_M5;
      default: return ELEM_NONE;
    endcase
  endfunction

  function automatic state_e next_elem_state(input state_e s);
    case (s)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      M5:      return FLUSH;
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/bist_addr_counter.sv
// Loadable up/down address counter; 'last' flags the terminal address of the
// current direction (mem_size-1 going up, 0 going down), never a natural wrap.
module bist_addr_counter #(
  parameter int addr_size = 10,
  parameter int mem_size  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 load_up,
  input  logic                 step,
  input  logic                 up,
  output logic [addr_size-1:0] cnt,
  output logic                 last
);

  localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(mem_size - 1);

  logic [addr_size-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_up ? '0 : LAST_ADDR;
    end else if (step) begin
      cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = up ? (cnt_q == LAST_ADDR) : (cnt_q == '0);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST controller for a single-port synchronous RAM with registered
// read data; reports the first failing address and march element.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int addr_size = 10,
  parameter int data_size = 8,
  parameter int mem_size  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 cs,
  output logic                 rw,
  output logic [addr_size-1:0] addr,
  output logic [data_size-1:0] d_in,
  input  logic [data_size-1:0] d_out,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [addr_size-1:0] fail_addr,
  output logic [2:0]           fail_elem
);

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic                 cs_q, cs_d, rw_q, rw_d, busy_q, busy_d, done_q, done_d;
  logic [data_size-1:0] d_in_q, d_in_d;
  logic                 cmp_vld_q, cmp_vld_d;
  logic [data_size-1:0] cmp_exp_q, cmp_exp_d;
  logic [addr_size-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]           cmp_elem_q, cmp_elem_d;
  logic                 fail_q, fail_d;
  logic [addr_size-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]           fail_elem_q, fail_elem_d;

  logic                 cnt_load, cnt_load_up, cnt_step, cnt_up, cnt_last;
  logic [addr_size-1:0] cnt;
  logic [2:0]           cur_elem, nxt_elem;
  logic                 two_op, start_ok;

  bist_addr_counter #(
    .addr_size (addr_size),
    .mem_size  (mem_size)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_up (cnt_load_up),
    .step    (cnt_step),
    .up      (cnt_up),
    .cnt     (cnt),
    .last    (cnt_last)
  );

  always_comb begin
    cur_elem = elem_num(state_q);
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    cnt_up   = ELEM_TBL[cur_elem].up;
    two_op   = ELEM_TBL[cur_elem].has_rd && ELEM_TBL[cur_elem].has_wr;
    start_ok = ((state_q == IDLE) || (state_q == DONE)) && start;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = M0;
          phase_d  = 1'b0;
          cnt_load = 1'b1;
        end
      end
      FLUSH: state_d = DONE;
      default: begin
        if (two_op && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (cnt_last) begin
            state_d  = next_elem_state(state_q);
            cnt_load = (state_d != FLUSH);
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
    endcase

    // Pin values for the op presented next cycle, decoded from the next state.
    nxt_elem    = elem_num(state_d);
    cnt_load_up = ELEM_TBL[nxt_elem].up;
    cs_d        = (nxt_elem != ELEM_NONE);
    rw_d        = cs_d && ELEM_TBL[nxt_elem].has_wr &&
                  (!ELEM_TBL[nxt_elem].has_rd || phase_d);
    d_in_d      = rw_d ? {data_size{ELEM_TBL[nxt_elem].wr_bg}} : '0;
    busy_d      = cs_d || (state_d == FLUSH);
    done_d      = (state_d == DONE);

    // A read on the pins now returns d_out next cycle; capture its context.
    cmp_vld_d  = cs_q && !rw_q;
    cmp_exp_d  = {data_size{ELEM_TBL[cur_elem].rd_bg}};
    cmp_addr_d = cnt;
    cmp_elem_d = cur_elem;

    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (cmp_vld_q && (d_out != cmp_exp_q) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      cs_q        <= 1'b0;
      rw_q        <= 1'b0;
      d_in_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cs_q        <= cs_d;
      rw_q        <= rw_d;
      d_in_q      <= d_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign cs        = cs_q;
  assign rw        = rw_q;
  assign addr      = cnt;
  assign d_in      = d_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist (mem_size=16) driving a synchronous RAM
// model with optional stuck-at and coupling faults.
module tb_ram_march_bist;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          cs, rw, busy, done, fail;
  logic [AW-1:0] addr, fail_addr;
  logic [DW-1:0] d_in, d_out;
  logic [2:0]    fail_elem;

  logic [DW-1:0] mem [0:MS-1];
  logic          stuck_en  = 1'b0;
  logic          couple_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  always #5 clk = ~clk;

  ram_march_bist #(.addr_size(AW), .data_size(DW), .mem_size(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cs        (cs),
    .rw        (rw),
    .addr      (addr),
    .d_in      (d_in),
    .d_out     (d_out),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  // Synchronous RAM with registered read data and injectable faults.
  always @(posedge clk) begin
    if (cs) begin
      if (rw) begin
        mem[addr[3:0]] <= (stuck_en && addr == 5) ? (d_in & 8'hF7) : d_in;
        if (couple_en && addr == 9) mem[8] <= d_in;
      end else begin
        d_out <= mem[addr[3:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start  = 1'b0;
    ecount = 0;
  endtask

  task automatic tick_to(input int t);
    while (ecount < t) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"}, 32'(cs), 0);
    chk({tag, "_rw"}, 32'(rw), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_din"}, 32'(d_in), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_faddr"}, 32'(fail_addr), 0);
    chk({tag, "_felem"}, 32'(fail_elem), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Fault-free run with pin-level spot checks and a start pulse while busy.
    do_start();
    chk("e0_cs", 32'(cs), 1);
    chk("e0_rw", 32'(rw), 1);
    chk("e0_addr", 32'(addr), 0);
    chk("e0_din", 32'(d_in), 8'h00);
    chk("e0_busy", 32'(busy), 1);
    tick();
    chk("e1_rw", 32'(rw), 1);
    chk("e1_addr", 32'(addr), 1);
    tick();
    chk("e2_addr", 32'(addr), 2);
    chk("e2_din", 32'(d_in), 8'h00);
    tick_to(15);
    chk("m0_last_rw", 32'(rw), 1);
    chk("m0_last_addr", 32'(addr), 15);
    tick_to(16);
    chk("m1_rd_rw", 32'(rw), 0);
    chk("m1_rd_addr", 32'(addr), 0);
    tick_to(17);
    chk("m1_wr_rw", 32'(rw), 1);
    chk("m1_wr_addr", 32'(addr), 0);
    chk("m1_wr_din", 32'(d_in), 8'hFF);
    tick_to(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_to(80);
    chk("m3_first_rw", 32'(rw), 0);
    chk("m3_first_addr", 32'(addr), 15);
    tick_to(159);
    chk("m5_last_cs", 32'(cs), 1);
    chk("m5_last_rw", 32'(rw), 0);
    chk("m5_last_addr", 32'(addr), 15);
    tick_to(160);
    chk("flush_cs", 32'(cs), 0);
    chk("flush_busy", 32'(busy), 1);
    chk("flush_done", 32'(done), 0);
    tick_to(161);
    chk("clean_done", 32'(done), 1);
    chk("clean_busy", 32'(busy), 0);
    chk("clean_fail", 32'(fail), 0);
    chk("clean_cs", 32'(cs), 0);

    // Stuck-at-0 on bit 3 of word 5: first caught by the M2 read of addr 5.
    stuck_en = 1'b1;
    do_start();
    tick_to(59);
    chk("sa0_pre_fail", 32'(fail), 0);
    tick_to(60);
    chk("sa0_fail", 32'(fail), 1);
    chk("sa0_faddr", 32'(fail_addr), 5);
    chk("sa0_felem", 32'(fail_elem), 2);
    tick_to(160);
    chk("sa0_done_early", 32'(done), 0);
    tick_to(161);
    chk("sa0_done", 32'(done), 1);
    chk("sa0_fail_end", 32'(fail), 1);
    chk("sa0_faddr_end", 32'(fail_addr), 5);
    chk("sa0_felem_end", 32'(fail_elem), 2);

    // Restart from DONE with fail set: cleared at once, then a clean run.
    stuck_en = 1'b0;
    do_start();
    chk("rs_fail", 32'(fail), 0);
    chk("rs_faddr", 32'(fail_addr), 0);
    chk("rs_felem", 32'(fail_elem), 0);
    chk("rs_busy", 32'(busy), 1);
    chk("rs_done", 32'(done), 0);
    tick_to(161);
    chk("rs_done_end", 32'(done), 1);
    chk("rs_fail_end", 32'(fail), 0);

    // Coupling 9 -> 8: M3 (descending) reads addr 8 after the w1 to addr 9.
    couple_en = 1'b1;
    do_start();
    tick_to(95);
    chk("cf_pre_fail", 32'(fail), 0);
    tick_to(96);
    chk("cf_fail", 32'(fail), 1);
    chk("cf_faddr", 32'(fail_addr), 8);
    chk("cf_felem", 32'(fail_elem), 3);
    tick_to(161);
    chk("cf_done", 32'(done), 1);
    chk("cf_faddr_end", 32'(fail_addr), 8);
    chk("cf_felem_end", 32'(fail_elem), 3);
    couple_en = 1'b0;

    // Reset mid-test, together with start: reset wins.
    do_start();
    tick_to(50);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk_all_zero("midrst");
    tick();
    chk("midrst_idle_cs", 32'(cs), 0);
    chk("midrst_idle_busy", 32'(busy), 0);
    do_start();
    chk("post_rst_busy", 32'(busy), 1);
    tick_to(160);
    chk("post_rst_done_early", 32'(done), 0);
    tick_to(161);
    chk("post_rst_done", 32'(done), 1);
    chk("post_rst_fail", 32'(fail), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
